// File: rtl/gb_line_scaler_if.sv
// Pixel-stream input, VGA coordinate input and scaled-pixel output of the GameBoy line scaler.
interface gb_line_scaler_if #(
    parameter int PIX_W = 2
);
    logic [PIX_W-1:0] in_pix;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic [15:0]      hcount;
    logic [15:0]      vcount;
    logic [PIX_W-1:0] out_pix;
    logic             out_valid;
    logic             frame_start;
    logic             underrun;

    modport master (
        output in_pix, in_valid, in_sof, hcount, vcount,
        input  in_ready, out_pix, out_valid, frame_start, underrun
    );

    modport slave (
        input  in_pix, in_valid, in_sof, hcount, vcount,
        output in_ready, out_pix, out_valid, frame_start, underrun
    );
endinterface

// File: rtl/gb_line_scaler.sv
// Ping-pong line buffer replaying GameBoy lines into a centred VGA window; outputs 1 clk after hcount/vcount.
// in_ready drops while two whole lines are buffered; GB_SCALER_GRID_EN overlays an LCD grid.
module gb_line_scaler #(
    parameter int               PIX_W    = 2,
    parameter int               SRC_W    = 160,
    parameter int               SRC_H    = 144,
    parameter int               X_SCALE  = 3,
    parameter int               Y_SCALE  = 3,
    parameter int               X_OFF    = 160,
    parameter int               Y_OFF    = 80,
    parameter logic [PIX_W-1:0] GRID_PIX = {PIX_W{1'b1}}
) (
    input  logic            clk,
    input  logic            reset_n,
    gb_line_scaler_if.slave bus
);
    localparam int CW  = (SRC_W > 1)   ? $clog2(SRC_W)   : 1;
    localparam int RW  = (SRC_H > 1)   ? $clog2(SRC_H)   : 1;
    localparam int XRW = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
    localparam int YRW = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;

    localparam logic [15:0]    X_LO     = 16'(X_OFF);
    localparam logic [15:0]    X_HI     = 16'(X_OFF + SRC_W * X_SCALE);
    localparam logic [15:0]    X_LAST   = 16'(X_OFF + SRC_W * X_SCALE - 1);
    localparam logic [15:0]    Y_LO     = 16'(Y_OFF);
    localparam logic [15:0]    Y_HI     = 16'(Y_OFF + SRC_H * Y_SCALE);
    localparam logic [CW-1:0]  COL_LAST = CW'(SRC_W - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(SRC_H - 1);
    localparam logic [XRW-1:0] XR_LAST  = XRW'(X_SCALE - 1);
    localparam logic [YRW-1:0] YR_LAST  = YRW'(Y_SCALE - 1);

    logic [PIX_W-1:0] r_mem [2][SRC_W];

    logic             r_in_ready;
    logic [1:0]       r_full_cnt;
    logic [CW-1:0]    r_wr_col;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [XRW-1:0]   r_col_rep;
    logic [CW-1:0]    r_rd_col;
    logic [YRW-1:0]   r_row_rep;
    logic [RW-1:0]    r_src_row;
    logic             r_idle;
    logic             r_urun_line;
    logic [PIX_W-1:0] r_out_pix;
    logic             r_out_valid;
    logic             r_frame_start;
    logic             r_underrun;

    logic             w_xfer;
    logic             w_wr_done;
    logic [CW-1:0]    w_wr_addr;
    logic             w_in_win;
    logic             w_line_start;
    logic             w_line_end;
    logic             w_fstart;
    logic             w_idle;
    logic             w_urun;
    logic [XRW-1:0]   w_col_rep;
    logic [CW-1:0]    w_rd_col;
    logic [YRW-1:0]   w_row_rep;
    logic [RW-1:0]    w_src_row;
    logic             w_adv;
    logic             w_release;
    logic             w_grid;
    logic [1:0]       w_full_nxt;
    logic [PIX_W-1:0] w_pix_nxt;

    assign w_xfer    = bus.in_valid && r_in_ready;
    assign w_wr_addr = bus.in_sof ? '0 : r_wr_col;
    assign w_wr_done = w_xfer && !bus.in_sof && (r_wr_col == COL_LAST);

    assign w_in_win     = (bus.hcount >= X_LO) && (bus.hcount < X_HI) &&
                          (bus.vcount >= Y_LO) && (bus.vcount < Y_HI);
    assign w_line_start = w_in_win && (bus.hcount == X_LO);
    assign w_line_end   = w_in_win && (bus.hcount == X_LAST);
    assign w_fstart     = w_line_start && (bus.vcount == Y_LO);

    // Line-start values are forced so a line always replays from column 0, even after an aborted line.
    assign w_idle    = w_fstart ? 1'b0 : r_idle;
    assign w_urun    = w_line_start ? ((r_full_cnt == 2'd0) && !w_idle) : r_urun_line;
    assign w_col_rep = w_line_start ? '0 : r_col_rep;
    assign w_rd_col  = w_line_start ? '0 : r_rd_col;
    assign w_row_rep = w_fstart ? '0 : r_row_rep;
    assign w_src_row = w_fstart ? '0 : r_src_row;

    assign w_adv     = w_line_end && !w_urun && !w_idle;
    assign w_release = w_adv && (w_row_rep == YR_LAST);

`ifdef GB_SCALER_GRID_EN
    assign w_grid = (w_col_rep == '0) || (w_row_rep == '0);
`else
    assign w_grid = 1'b0;
`endif

    always_comb begin
        w_full_nxt = r_full_cnt;
        if (w_wr_done && !w_release) begin
            w_full_nxt = r_full_cnt + 2'd1;
        end else if (!w_wr_done && w_release) begin
            w_full_nxt = r_full_cnt - 2'd1;
        end
    end

    always_comb begin
        w_pix_nxt = '0;
        if (w_in_win) begin
            if (!w_urun && !w_idle) begin
                w_pix_nxt = r_mem[r_rd_bank][w_rd_col];
            end
            if (w_grid) begin
                w_pix_nxt = GRID_PIX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[r_wr_bank][w_wr_addr] <= bus.in_pix;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_ready    <= 1'b0;
            r_full_cnt    <= '0;
            r_wr_col      <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_col_rep     <= '0;
            r_rd_col      <= '0;
            r_row_rep     <= '0;
            r_src_row     <= '0;
            r_idle        <= 1'b0;
            r_urun_line   <= 1'b0;
            r_out_pix     <= '0;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_full_cnt <= w_full_nxt;
            r_in_ready <= (w_full_nxt != 2'd2);
            if (w_xfer) begin
                if (w_wr_done) begin
                    r_wr_col  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_col <= w_wr_addr + 1'b1;
                end
            end

            r_out_pix     <= w_pix_nxt;
            r_out_valid   <= w_in_win;
            r_frame_start <= w_fstart;
            r_underrun    <= w_line_start && w_urun;

            if (w_in_win) begin
                r_urun_line <= w_urun;
                r_idle      <= w_idle;
                if (w_col_rep == XR_LAST) begin
                    r_col_rep <= '0;
                    r_rd_col  <= (w_rd_col == COL_LAST) ? '0 : w_rd_col + 1'b1;
                end else begin
                    r_col_rep <= w_col_rep + 1'b1;
                    r_rd_col  <= w_rd_col;
                end
                r_row_rep <= w_row_rep;
                r_src_row <= w_src_row;
                if (w_adv) begin
                    if (w_row_rep == YR_LAST) begin
                        r_row_rep <= '0;
                        r_rd_bank <= ~r_rd_bank;
                        // Last source row of the frame: hold off until the next frame_start.
                        if (w_src_row == ROW_LAST) begin
                            r_src_row <= '0;
                            r_idle    <= 1'b1;
                        end else begin
                            r_src_row <= w_src_row + 1'b1;
                        end
                    end else begin
                        r_row_rep <= w_row_rep + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_pix     = r_out_pix;
    assign bus.out_valid   = r_out_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.underrun    = r_underrun;
endmodule

// File: tb/tb_gb_line_scaler.sv
// Self-checking bench for gb_line_scaler: constant vector table, directed corner sequences and a
// line-level reference model (queue of completed source lines, window arithmetic by division).
module tb_gb_line_scaler;
    localparam int PIX_W = 2;
    localparam int SRC_W = 160;
    localparam int SRC_H = 144;
    localparam int XS    = 3;
    localparam int YS    = 3;
    localparam int XO    = 160;
    localparam int YO    = 80;
    localparam int WIN_W = SRC_W * XS;
    localparam int WIN_H = SRC_H * YS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gb_line_scaler_if #(.PIX_W(PIX_W)) bus ();

    gb_line_scaler #(
        .PIX_W(PIX_W), .SRC_W(SRC_W), .SRC_H(SRC_H), .X_SCALE(XS), .Y_SCALE(YS),
        .X_OFF(XO), .Y_OFF(YO), .GRID_PIX(2'b11)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Reference model state
    logic [2*SRC_W-1:0] m_q[$];
    logic [2*SRC_W-1:0] m_part;
    int  m_wcol, m_disp, m_row;
    bit  m_idle, m_lur, m_ready;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  s_rdy;
    logic [1:0] cap [WIN_W];

    typedef struct {
        int h;
        int v;
        bit vld;
        bit fs;
        bit ur;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, update the model, compare registered outputs after the edge.
    task automatic step(input bit vld, input logic [1:0] pix, input bit sof,
                        input int h, input int v, input bit cp);
        bit e_vld, e_fs, e_ur, rel, xfer;
        int e_pix, x;
        logic [2*SRC_W-1:0] ln;
        e_vld = 0; e_fs = 0; e_ur = 0; rel = 0; e_pix = 0; x = -1;
        @(negedge clk);
        bus.in_valid = vld;
        bus.in_pix   = pix;
        bus.in_sof   = sof;
        bus.hcount   = 16'(h);
        bus.vcount   = 16'(v);
        s_rdy = bus.in_ready;
        chk("in_ready", int'(bus.in_ready), int'(m_ready));
        xfer = vld && m_ready;
        if (h >= XO && h < XO + WIN_W && v >= YO && v < YO + WIN_H) begin
            x = h - XO;
            e_vld = 1;
            if (x == 0) begin
                if (v == YO) begin
                    e_fs = 1; m_row = 0; m_disp = 0; m_idle = 0;
                end
                m_lur = !m_idle && (m_q.size() == 0);
                e_ur = m_lur;
            end
            if (!m_lur && !m_idle && m_q.size() > 0) begin
                ln = m_q[0];
                e_pix = int'(ln[(x / XS) * 2 +: 2]);
            end
            if (x == WIN_W - 1 && !m_lur && !m_idle) begin
                m_disp++;
                if (m_disp == YS) begin
                    m_disp = 0; rel = 1; m_row++;
                    if (m_row == SRC_H) begin
                        m_row = 0; m_idle = 1;
                    end
                end
            end
        end
        if (rel && m_q.size() > 0) void'(m_q.pop_front());
        if (xfer) begin
            if (sof) begin
                m_part[1:0] = pix;
                m_wcol = 1;
            end else begin
                m_part[m_wcol * 2 +: 2] = pix;
                if (m_wcol == SRC_W - 1) begin
                    m_q.push_back(m_part);
                    m_wcol = 0;
                end else begin
                    m_wcol++;
                end
            end
        end
        m_ready = (m_q.size() < 2);
        @(posedge clk);
        #1;
        chk($sformatf("out_valid(%0d,%0d)", h, v), int'(bus.out_valid), int'(e_vld));
        chk($sformatf("frame_start(%0d,%0d)", h, v), int'(bus.frame_start), int'(e_fs));
        chk($sformatf("underrun(%0d,%0d)", h, v), int'(bus.underrun), int'(e_ur));
        if (cp) chk($sformatf("out_pix(%0d,%0d)", h, v), int'(bus.out_pix), e_pix);
        if (x >= 0) cap[x] = bus.out_pix;
    endtask

    task automatic scan_line(input int v, input bit rnd_wr);
        bit vld, sof;
        logic [1:0] p;
        for (int h = XO - 2; h < XO + WIN_W + 2; h++) begin
            vld = 0; sof = 0; p = 2'($urandom);
            if (rnd_wr) begin
                vld = 1'($urandom_range(0, 1));
                sof = ($urandom_range(0, 299) == 0);
            end
            step(vld, p, sof, h, v, 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.in_valid = 0; bus.in_sof = 0; bus.in_pix = 0; bus.hcount = 0; bus.vcount = 0;
        #1;
        chk("rst.in_ready", int'(bus.in_ready), 0);
        chk("rst.out_valid", int'(bus.out_valid), 0);
        chk("rst.out_pix", int'(bus.out_pix), 0);
        chk("rst.frame_start", int'(bus.frame_start), 0);
        chk("rst.underrun", int'(bus.underrun), 0);
        m_q.delete();
        m_part = '0; m_wcol = 0; m_disp = 0; m_row = 0;
        m_idle = 0; m_lur = 0; m_ready = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1;
        chk("rst.in_ready_after_release", int'(bus.in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_x, n;
        tbl[0]  = '{100,   50,    0, 0, 0};
        tbl[1]  = '{160,   79,    0, 0, 0};
        tbl[2]  = '{160,   80,    1, 1, 1};
        tbl[3]  = '{161,   80,    1, 0, 0};
        tbl[4]  = '{639,   80,    1, 0, 0};
        tbl[5]  = '{640,   80,    0, 0, 0};
        tbl[6]  = '{160,   81,    1, 0, 1};
        tbl[7]  = '{159,   81,    0, 0, 0};
        tbl[8]  = '{160,   511,   1, 0, 1};
        tbl[9]  = '{160,   512,   0, 0, 0};
        tbl[10] = '{639,   511,   1, 0, 0};
        tbl[11] = '{65535, 65535, 0, 0, 0};

        bus.in_valid = 0; bus.in_sof = 0; bus.in_pix = 0; bus.hcount = 0; bus.vcount = 0;
        do_reset();

        // Window boundaries and underrun on an empty buffer
        for (int i = 0; i < 12; i++) begin
            step(0, 2'd0, 0, tbl[i].h, tbl[i].v, 1);
            chk($sformatf("tbl%0d.valid", i), int'(bus.out_valid), int'(tbl[i].vld));
            chk($sformatf("tbl%0d.frame_start", i), int'(bus.frame_start), int'(tbl[i].fs));
            chk($sformatf("tbl%0d.underrun", i), int'(bus.underrun), int'(tbl[i].ur));
            chk($sformatf("tbl%0d.pix", i), int'(bus.out_pix), 0);
        end

        // Full-line underrun: 480 zero pixels, pulse only at the first window column
        scan_line(81, 0);

        // Fill two ramp lines with in_valid held: exactly 320 transfers then stall
        n_x = 0;
        for (int i = 0; i < 400; i++) begin
            step(1, 2'(m_wcol % 4), 0, 0, 0, 1);
            if (s_rdy) n_x++;
        end
        chk("fill.transfers", n_x, 320);
        chk("fill.ready_low", int'(s_rdy), 0);

        // Replay: 3 lines of the first ramp line, then one release
        scan_line(80, 0);
        chk("ramp.cap0", int'(cap[0]), 0);
        chk("ramp.cap2", int'(cap[2]), 0);
        chk("ramp.cap3", int'(cap[3]), 1);
        chk("ramp.cap8", int'(cap[8]), 2);
        chk("ramp.cap9", int'(cap[9]), 3);
        chk("ramp.cap479", int'(cap[479]), 3);
        scan_line(81, 0);
        chk("ramp.ready_still_low", int'(s_rdy), 0);
        scan_line(82, 0);
        chk("ramp.ready_after_release", int'(s_rdy), 1);

        // in_sof mid-line: partial 57 pixels discarded, 160 more fill the buffer
        for (int i = 0; i < 57; i++) step(1, 2'($urandom), 0, 0, 0, 1);
        step(1, 2'($urandom), 1, 0, 0, 1);
        n_x = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 2'($urandom), 0, 0, 0, 1);
            if (s_rdy) n_x++;
        end
        chk("sof.transfers_after_sof", n_x, 159);
        for (int v = 83; v < 86; v++) scan_line(v, 0);

        // Release and write-complete on the same clock at full_cnt=1
        for (int i = 0; i < 159; i++) step(1, 2'($urandom), 0, 0, 0, 1);
        scan_line(86, 0);
        scan_line(87, 0);
        for (int h = XO - 2; h < XO + WIN_W + 2; h++)
            step(h == XO + WIN_W - 1, 2'($urandom), 0, h, 88, 1);
        chk("simul.ready_stays_high", int'(s_rdy), 1);
        n_x = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 2'($urandom), 0, 0, 0, 1);
            if (s_rdy) n_x++;
        end
        chk("simul.one_line_of_room", n_x, 160);

        // Randomised writer running against continuous scanning
        for (int v = 89; v < 109; v++) scan_line(v, 1);

        // Whole frame of short lines (first and last window column) to reach the frame end
        for (int v = YO; v < YO + WIN_H; v++) begin
            n = 0;
            while (m_q.size() == 0 && n < 400) begin
                step(1, 2'($urandom), 0, 0, 0, 1);
                n++;
            end
            step(0, 2'd0, 0, XO, v, 1);
            step(0, 2'd0, 0, XO + WIN_W - 1, v, 0);
        end
        n = 0;
        while (m_q.size() == 0 && n < 400) begin
            step(1, 2'($urandom), 0, 0, 0, 1);
            n++;
        end
        // A stray window line after the frame end must not consume the buffered line
        step(0, 2'd0, 0, XO, 100, 1);
        chk("idle.no_underrun", int'(bus.underrun), 0);
        step(0, 2'd0, 0, XO + WIN_W - 1, 100, 0);
        scan_line(YO, 0);

        // Asynchronous reset in the middle of a window line
        for (int h = XO - 2; h < 300; h++) step(0, 2'd0, 0, h, 81, 1);
        do_reset();
        step(0, 2'd0, 0, XO, YO, 1);
        chk("post_rst.frame_start", int'(bus.frame_start), 1);
        chk("post_rst.underrun", int'(bus.underrun), 1);
        for (int i = 0; i < SRC_W; i++) step(1, 2'(i % 4), 0, 0, 0, 1);
        scan_line(81, 0);
        chk("post_rst.cap0", int'(cap[0]), 0);
        chk("post_rst.cap6", int'(cap[6]), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
